// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - shared types and encodings for the multicycle MIPS control FSM
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

endpackage

// File: rtl/mips_alu_decoder.sv
// rtl/mips_alu_decoder.sv - ALUOp/funct to ALUControl decode with funct legality flag
module mips_alu_decoder
  import mips_mc_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  alu_op_e              alu_op_i,
  input  logic [5:0]           funct_i,
  output logic [ALUCTRL_W-1:0] alu_control_o,
  output logic                 funct_legal_o
);

  logic [2:0] funct_ctrl;

  // Legality depends on funct alone so DECODE can use it while ALUOp is ADD.
  always_comb begin
    funct_ctrl    = ALUC_ADD;
    funct_legal_o = 1'b1;
    case (funct_i)
      FN_ADD:  funct_ctrl = ALUC_ADD;
      FN_SUB:  funct_ctrl = ALUC_SUB;
      FN_AND:  funct_ctrl = ALUC_AND;
      FN_OR:   funct_ctrl = ALUC_OR;
      FN_SLT:  funct_ctrl = ALUC_SLT;
      default: funct_legal_o = 1'b0;
    endcase
  end

  always_comb begin
    alu_control_o = ALUCTRL_W'(ALUC_ADD);
    case (alu_op_i)
      ALUOP_SUB:   alu_control_o = ALUCTRL_W'(ALUC_SUB);
      ALUOP_FUNCT: alu_control_o = ALUCTRL_W'(funct_ctrl);
      default:     alu_control_o = ALUCTRL_W'(ALUC_ADD);
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM with memory handshake and retire counter
module mips_multicycle_ctrl
  import mips_mc_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 mem_ready,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 Branch,
  output logic [1:0]           PCSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 instr_done,
  output logic                 illegal_op,
  output logic [CNT_W-1:0]     instr_count
);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  alu_op_e                alu_op;
  logic                   alu_used;
  logic [ALUCTRL_W-1:0]   alu_control;
  logic                   funct_legal;

  mips_alu_decoder #(
    .ALUCTRL_W(ALUCTRL_W)
  ) u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct_i       (funct),
    .alu_control_o (alu_control),
    .funct_legal_o (funct_legal)
  );

  // States that do not drive the ALU present ALUControl as 0.
  always_comb begin
    alu_op   = ALUOP_ADD;
    alu_used = 1'b0;
    case (state_q)
      S_FETCH, S_DECODE, S_MEMADR, S_ADDIEX: alu_used = 1'b1;
      S_EXECUTE: begin
        alu_used = 1'b1;
        alu_op   = ALUOP_FUNCT;
      end
      S_BRANCH: begin
        alu_used = 1'b1;
        alu_op   = ALUOP_SUB;
      end
      default: alu_used = 1'b0;
    endcase
  end

  assign ALUControl  = (alu_used && !reset) ? alu_control : '0;
  assign instr_count = reset ? '0 : count_q;

  always_comb begin
    state_d    = state_q;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          OP_RTYPE: begin
            if (funct_legal) begin
              state_d = S_EXECUTE;
            end else begin
              state_d    = S_FETCH;
              illegal_op = 1'b1;
            end
          end
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        Branch     = 1'b1;
        PCSrc      = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        PCSrc      = 2'b10;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset masks every strobe immediately, including a write already in flight.
    if (reset) begin
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      Branch     = 1'b0;
      PCSrc      = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
    count_d = instr_done ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - randomized self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

  localparam int CNT_W = 4;

  localparam int K_FETCH = 0, K_DECODE = 1, K_MEMADR = 2, K_MEMRD = 3, K_MEMWB = 4,
                 K_MEMWR = 5, K_EXEC = 6, K_ALUWB = 7, K_BRANCH = 8, K_ADDIEX = 9,
                 K_ADDIWB = 10, K_JUMP = 11;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [2:0] alu_ctl;
    logic       done;
    logic       illegal;
  } ctl_t;

  logic             clk;
  logic             reset;
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             mem_ready;
  logic             IorD, MemWrite, IRWrite, PCWrite, Branch;
  logic [1:0]       PCSrc;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic             RegDst, MemtoReg, RegWrite;
  logic [2:0]       ALUControl;
  logic             instr_done, illegal_op;
  logic [CNT_W-1:0] instr_count;
  ctl_t             dut_ctl;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;

  mips_multicycle_ctrl #(
    .CNT_W(CNT_W),
    .ALUCTRL_W(3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct       (funct),
    .mem_ready   (mem_ready),
    .IorD        (IorD),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .PCWrite     (PCWrite),
    .Branch      (Branch),
    .PCSrc       (PCSrc),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .ALUControl  (ALUControl),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
    .instr_count (instr_count)
  );

  assign dut_ctl = {IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB,
                    RegDst, MemtoReg, RegWrite, ALUControl, instr_done, illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit funct_ok(input logic [5:0] f);
    return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
           f == 6'b100101 || f == 6'b101010;
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic bit op_known(input logic [5:0] o);
    return o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
           o == 6'b000100 || o == 6'b001000 || o == 6'b000010;
  endfunction

  function automatic ctl_t exp_ctl(input int k, input bit mr, input logic [5:0] o, input logic [5:0] f);
    ctl_t c;
    c = '0;
    case (k)
      K_FETCH:  begin c.alu_src_b = 2'b01; c.alu_ctl = 3'b010; c.ir_write = mr; c.pc_write = mr; end
      K_DECODE: begin
        c.alu_src_b = 2'b11; c.alu_ctl = 3'b010;
        c.illegal = !op_known(o) || (o == 6'b000000 && !funct_ok(f));
      end
      K_MEMADR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_ctl = 3'b010; end
      K_MEMRD:  c.iord = 1;
      K_MEMWB:  begin c.mem_to_reg = 1; c.reg_write = 1; c.done = 1; end
      K_MEMWR:  begin c.iord = 1; c.mem_write = 1; c.done = mr; end
      K_EXEC:   begin c.alu_src_a = 1; c.alu_ctl = funct_alu(f); end
      K_ALUWB:  begin c.reg_dst = 1; c.reg_write = 1; c.done = 1; end
      K_BRANCH: begin c.alu_src_a = 1; c.alu_ctl = 3'b110; c.branch = 1; c.pc_src = 2'b01; c.done = 1; end
      K_ADDIEX: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_ctl = 3'b010; end
      K_ADDIWB: begin c.reg_write = 1; c.done = 1; end
      K_JUMP:   begin c.pc_src = 2'b10; c.pc_write = 1; c.done = 1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      reset = 1'b1;
      mem_ready = 1'b1;
      op = 6'($urandom);
      funct = 6'($urandom);
      #1;
      check("rst_ctl", 32'(dut_ctl), 32'd0);
      check("rst_cnt", 32'(instr_count), 32'd0);
    end
    model_cnt = 0;
  endtask

  // fixed_stalls applies to the memory access steps only when rnd is clear.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input bit rnd,
                           input int fixed_stalls, input bit abort_in_write);
    int   steps[$];
    int   waits;
    bit   mr;
    bit   wait_step;
    ctl_t e;
    steps = {K_FETCH, K_DECODE};
    if (o == 6'b100011)      steps = {steps, K_MEMADR, K_MEMRD, K_MEMWB};
    else if (o == 6'b101011) steps = {steps, K_MEMADR, K_MEMWR};
    else if (o == 6'b000100) steps = {steps, K_BRANCH};
    else if (o == 6'b001000) steps = {steps, K_ADDIEX, K_ADDIWB};
    else if (o == 6'b000010) steps = {steps, K_JUMP};
    else if (o == 6'b000000 && funct_ok(f)) steps = {steps, K_EXEC, K_ALUWB};
    foreach (steps[i]) begin
      wait_step = steps[i] == K_FETCH || steps[i] == K_MEMRD || steps[i] == K_MEMWR;
      if (!wait_step)              waits = 0;
      else if (rnd)                waits = $urandom_range(0, 2);
      else if (steps[i] == K_FETCH) waits = 0;
      else                         waits = fixed_stalls;
      for (int w = 0; w <= waits; w++) begin
        mr = wait_step ? (w == waits) : 1'($urandom);
        @(negedge clk);
        reset = 1'b0;
        mem_ready = mr;
        op = (steps[i] == K_FETCH) ? 6'($urandom) : o;
        funct = (steps[i] == K_FETCH) ? 6'($urandom) : f;
        #1;
        e = exp_ctl(steps[i], mr, o, f);
        check($sformatf("ctl_s%0d_op%b", steps[i], o), 32'(dut_ctl), 32'(e));
        check("cnt", 32'(instr_count), 32'(model_cnt % (1 << CNT_W)));
        if (abort_in_write && steps[i] == K_MEMWR && !mr) begin
          do_reset(2);
          return;
        end
        if (e.done) model_cnt++;
      end
    end
  endtask

  initial begin
    logic [5:0] rf;
    logic [5:0] ro;
    reset = 1'b1;
    mem_ready = 1'b0;
    op = '0;
    funct = '0;
    do_reset(2);

    run_instr(6'b100011, 6'd0, 0, 0, 0);
    run_instr(6'b101011, 6'd0, 0, 3, 0);
    run_instr(6'b000000, 6'b101010, 0, 0, 0);
    run_instr(6'b000100, 6'd0, 0, 0, 0);
    run_instr(6'b001000, 6'd0, 0, 0, 0);
    run_instr(6'b111111, 6'd0, 0, 0, 0);
    run_instr(6'b000000, 6'b000111, 0, 0, 0);
    run_instr(6'b101011, 6'd0, 0, 3, 1);
    check("cnt_after_rst", 32'(instr_count), 32'd0);

    for (int i = 0; i < 17; i++) run_instr(6'b000010, 6'd0, 0, 0, 0);

    for (int i = 0; i < 200; i++) begin
      rf = 6'($urandom);
      case ($urandom_range(0, 7))
        0: run_instr(6'b100011, rf, 1, 0, 0);
        1: run_instr(6'b101011, rf, 1, 0, 0);
        2: begin
          do rf = 6'($urandom); while (!funct_ok(rf));
          run_instr(6'b000000, rf, 1, 0, 0);
        end
        3: run_instr(6'b000100, rf, 1, 0, 0);
        4: run_instr(6'b001000, rf, 1, 0, 0);
        5: run_instr(6'b000010, rf, 1, 0, 0);
        6: begin
          do ro = 6'($urandom); while (op_known(ro));
          run_instr(ro, rf, 1, 0, 0);
        end
        default: begin
          do rf = 6'($urandom); while (funct_ok(rf));
          run_instr(6'b000000, rf, 1, 0, 0);
        end
      endcase
    end

    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("final_cnt", 32'(instr_count), 32'(model_cnt % (1 << CNT_W)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
